// File: rtl/core_pkg.sv
// Shared types and constants for the attention-core tile sequencer.
// Holds the FSM state enum, inst-word bit positions and memory depths.
package core_pkg;

    localparam int QK_DEPTH   = 16;
    localparam int PMEM_DEPTH = 16;
    localparam int MAX_N      = (QK_DEPTH < PMEM_DEPTH) ? QK_DEPTH : PMEM_DEPTH;

    localparam int INST_W        = 20;
    localparam int INST_GET_SUM  = 19;
    localparam int INST_DIV      = 18;
    localparam int INST_ACC      = 17;
    localparam int INST_OFIFO_RD = 16;
    localparam int INST_QK_ADD   = 12;
    localparam int INST_P_ADD    = 8;
    localparam int INST_EXE      = 7;
    localparam int INST_KLD      = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LDQ,
        ST_LDK,
        ST_KLD,
        ST_EXE,
        ST_DRN,
        ST_OFR,
        ST_ACC,
        ST_SYN,
        ST_DIV,
        ST_FIN
    } state_e;

endpackage

// File: rtl/core_ctrl_if.sv
// Command, mem_in handshake and status bundle of the tile sequencer.
// master = command source / data feeder, slave = core_ctrl.
interface core_ctrl_if;
    import core_pkg::*;

    logic              start;
    logic [4:0]        n_q;
    logic              data_valid;
    logic              data_ready;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, n_q, data_valid,
        input  data_ready, inst, busy, done, err
    );

    modport slave (
        input  start, n_q, data_valid,
        output data_ready, inst, busy, done, err
    );

endinterface

// File: rtl/core_ctrl_cnt.sv
// Loadable index counter shared by every phase loop of core_ctrl.
// tc flags the last index (lim-1); an increment at tc wraps to 0.
module core_ctrl_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc  = (cnt_q == lim - W'(1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Instruction sequencer for one attention-core tile (load, kernel, exec, drain, norm).
// Define CORE_CTRL_NORM_EN to enable the ACC / SYN / DIV normalization phases.
module core_ctrl
    import core_pkg::*;
#(
    parameter int col       = 8,
    parameter int DRAIN_CYC = 12,
    parameter int SYNC_CYC  = 4
) (
    input  logic       clk,
    input  logic       reset,
    core_ctrl_if.slave bus
);

    localparam logic [4:0] COL_LIM = 5'(col);
    localparam logic [4:0] DRN_LIM = 5'(DRAIN_CYC);
    localparam logic [4:0] SYN_LIM = 5'(SYNC_CYC + 1);

    state_e            state_q, state_d;
    logic [4:0]        nq_q, nq_d;
    logic              div_wr_q, div_wr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic       cnt_clr, cnt_inc, cnt_tc;
    logic [4:0] cnt_lim, cnt;
    logic       loading, hs, start_seen, n_bad;

    assign loading = (state_q == ST_LDQ) || (state_q == ST_LDK);
    assign hs      = loading && bus.data_valid;
    // done_q marks the FIN cycle's output slot; a start seen there is dropped
    assign start_seen = (state_q == ST_IDLE) && bus.start && !done_q;
    assign n_bad      = (bus.n_q == 5'd0) || (bus.n_q > 5'(MAX_N));

    core_ctrl_cnt #(.W(5)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .lim   (cnt_lim),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            nq_q     <= '0;
            div_wr_q <= 1'b0;
            inst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nq_q     <= nq_d;
            div_wr_q <= div_wr_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nq_d     = nq_q;
        div_wr_d = div_wr_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_lim  = nq_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (start_seen && !n_bad) begin
                    state_d = ST_LDQ;
                    nq_d    = bus.n_q;
                end
            end
            ST_LDQ: begin
                cnt_inc = hs;
                if (hs && cnt_tc) state_d = ST_LDK;
            end
            ST_LDK: begin
                cnt_lim = COL_LIM;
                cnt_inc = hs;
                if (hs && cnt_tc) state_d = ST_KLD;
            end
            ST_KLD: begin
                cnt_lim = COL_LIM;
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_EXE;
            end
            ST_EXE: begin
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_DRN;
            end
            ST_DRN: begin
                cnt_lim = DRN_LIM;
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_OFR;
            end
            ST_OFR: begin
                cnt_inc = 1'b1;
`ifdef CORE_CTRL_NORM_EN
                if (cnt_tc) state_d = ST_ACC;
`else
                if (cnt_tc) state_d = ST_FIN;
`endif
            end
            ST_ACC: begin
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_SYN;
            end
            ST_SYN: begin
                cnt_lim = SYN_LIM;
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_DIV;
            end
            ST_DIV: begin
                // row index advances only after the write half
                cnt_inc  = div_wr_q;
                div_wr_d = !div_wr_q;
                if (div_wr_q && cnt_tc) state_d = ST_FIN;
            end
            ST_FIN: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inst_d = '0;
        done_d = (state_q == ST_FIN);
        err_d  = start_seen && n_bad;
        busy_d = (state_d != ST_IDLE);
        unique case (state_q)
            ST_LDQ: if (hs) begin
                inst_d[INST_QMEM_WR]     = 1'b1;
                inst_d[INST_QK_ADD +: 4] = cnt[3:0];
            end
            ST_LDK: if (hs) begin
                inst_d[INST_KMEM_WR]     = 1'b1;
                inst_d[INST_QK_ADD +: 4] = cnt[3:0];
            end
            ST_KLD: begin
                inst_d[INST_KLD]         = 1'b1;
                inst_d[INST_KMEM_RD]     = 1'b1;
                inst_d[INST_QK_ADD +: 4] = cnt[3:0];
            end
            ST_EXE: begin
                inst_d[INST_EXE]         = 1'b1;
                inst_d[INST_QMEM_RD]     = 1'b1;
                inst_d[INST_QK_ADD +: 4] = cnt[3:0];
            end
            ST_OFR: begin
                inst_d[INST_OFIFO_RD]   = 1'b1;
                inst_d[INST_PMEM_WR]    = 1'b1;
                inst_d[INST_P_ADD +: 4] = cnt[3:0];
            end
            ST_ACC: begin
                inst_d[INST_ACC]        = 1'b1;
                inst_d[INST_PMEM_RD]    = 1'b1;
                inst_d[INST_P_ADD +: 4] = cnt[3:0];
            end
            ST_SYN: inst_d[INST_GET_SUM] = (cnt == 5'd0);
            ST_DIV: begin
                inst_d[INST_DIV]        = 1'b1;
                inst_d[INST_PMEM_RD]    = !div_wr_q;
                inst_d[INST_PMEM_WR]    = div_wr_q;
                inst_d[INST_P_ADD +: 4] = cnt[3:0];
            end
            default: inst_d = '0;
        endcase
`ifndef CORE_CTRL_NORM_EN
        inst_d[INST_GET_SUM] = 1'b0;
        inst_d[INST_DIV]     = 1'b0;
        inst_d[INST_ACC]     = 1'b0;
`endif
    end

    assign bus.data_ready = loading;
    assign bus.inst       = inst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed flows with random mem_in stalls
// compared per cycle against a phase-list model of the instruction stream.
module tb_core_ctrl;

    localparam int COL   = 8;
    localparam int DRAIN = 12;
    localparam int SYNC  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    core_ctrl_if bus ();

    core_ctrl #(
        .col       (COL),
        .DRAIN_CYC (DRAIN),
        .SYNC_CYC  (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid always high, 1: toggles 1,0,1,0..., 2: random
    task automatic run_flow(input int n, input int mode);
        logic [19:0] ew[$];
        logic [19:0] w;
        bit          vp[$];
        bit          v;
        int          beats, stalls, lat_exp, done_at;
        beats  = 0;
        stalls = 0;
        while (beats < n + COL) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (vp.size() % 2) == 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            vp.push_back(v);
            w = '0;
            if (v) begin
                if (beats < n) begin
                    w[4] = 1'b1;
                    w[15:12] = 4'(beats);
                end else begin
                    w[2] = 1'b1;
                    w[15:12] = 4'(beats - n);
                end
                beats++;
            end else begin
                stalls++;
            end
            ew.push_back(w);
        end
        for (int i = 0; i < COL; i++) begin
            w = '0; w[6] = 1'b1; w[3] = 1'b1; w[15:12] = 4'(i);
            ew.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            w = '0; w[7] = 1'b1; w[5] = 1'b1; w[15:12] = 4'(i);
            ew.push_back(w);
        end
        for (int i = 0; i < DRAIN; i++) ew.push_back(20'h0);
        for (int i = 0; i < n; i++) begin
            w = '0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(i);
            ew.push_back(w);
        end
`ifdef CORE_CTRL_NORM_EN
        for (int i = 0; i < n; i++) begin
            w = '0; w[17] = 1'b1; w[1] = 1'b1; w[11:8] = 4'(i);
            ew.push_back(w);
        end
        ew.push_back(20'h80000);
        for (int i = 0; i < SYNC; i++) ew.push_back(20'h0);
        for (int i = 0; i < n; i++) begin
            w = '0; w[18] = 1'b1; w[1] = 1'b1; w[11:8] = 4'(i);
            ew.push_back(w);
            w[1] = 1'b0; w[0] = 1'b1;
            ew.push_back(w);
        end
        lat_exp = 2 + n + COL + COL + n + DRAIN + n + n + 1 + SYNC + 2 * n + 1;
`else
        lat_exp = 2 + n + COL + COL + n + DRAIN + n + 1;
`endif
        lat_exp += stalls;
        ew.push_back(20'h0);

        bus.start = 1'b1;
        bus.n_q   = 5'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("accept_inst", 32'(bus.inst), 32'h0);
        chk("accept_busy", 32'(bus.busy), 32'h1);
        chk("accept_ready", 32'(bus.data_ready), 32'h1);
        done_at = -1;
        for (int k = 1; k <= ew.size(); k++) begin
            if (k <= vp.size()) bus.data_valid = vp[k-1];
            else bus.data_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("inst", 32'(bus.inst), 32'(ew[k-1]));
            chk("done", 32'(bus.done), 32'(k == ew.size()));
            chk("busy", 32'(bus.busy), 32'(k != ew.size()));
            chk("err", 32'(bus.err), 32'h0);
            if (bus.done && done_at < 0) done_at = k;
        end
        bus.data_valid = 1'b0;
        chk("latency", 32'(done_at + 2), 32'(lat_exp));
    endtask

    initial begin
        bit found;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.n_q        = '0;
        bus.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", 32'(bus.inst), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_ready", 32'(bus.data_ready), 32'h0);
        reset = 1'b0;
        idle();

        run_flow(8, 0);
        idle();
        run_flow(3, 1);
        idle();

        bus.start = 1'b1;
        bus.n_q   = 5'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("nq0_err", 32'(bus.err), 32'h1);
        chk("nq0_busy", 32'(bus.busy), 32'h0);
        chk("nq0_inst", 32'(bus.inst), 32'h0);
        idle();
        chk("nq0_err_clr", 32'(bus.err), 32'h0);
        bus.start = 1'b1;
        bus.n_q   = 5'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("nq17_err", 32'(bus.err), 32'h1);
        chk("nq17_busy", 32'(bus.busy), 32'h0);
        chk("nq17_inst", 32'(bus.inst), 32'h0);
        idle();
        chk("nq17_err_clr", 32'(bus.err), 32'h0);
        chk("nq17_ready", 32'(bus.data_ready), 32'h0);

        bus.start      = 1'b1;
        bus.n_q        = 5'd8;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.inst[7] && bus.inst[15:12] == 4'd4) found = 1'b1;
        end
        chk("exe_row4_seen", 32'(found), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_inst", 32'(bus.inst), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_ready", 32'(bus.data_ready), 32'h0);
        reset = 1'b0;
        idle();
        run_flow(2, 0);
        idle();

        run_flow(16, 2);
        bus.start = 1'b1;
        bus.n_q   = 5'd1;
        @(posedge clk);
        #1;
        chk("done_cyc_start_busy", 32'(bus.busy), 32'h0);
        chk("done_cyc_start_err", 32'(bus.err), 32'h0);
        chk("done_cyc_start_inst", 32'(bus.inst), 32'h0);
        run_flow(1, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
